// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_part_next;

    // Full-subtractor cell on the current LSBs and the running borrow
    assign w_ai        = r_a[0];
    assign w_bi        = r_b[0];
    assign w_d         = w_ai ^ w_bi ^ r_br;
    assign w_br_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_part_next = {w_d, r_part[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_part <= w_part_next;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CW'(1);
                    // Final bit: publish the result on the edge entering DONE
                    if (w_last) begin
                        diff    <= w_part_next;
                        bout    <= w_br_next;
                        ovf     <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;

    int unsigned n_total;
    int unsigned n_pass;
    logic [3:0]  held_diff;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic tbin, input logic [3:0] ed, input logic eb, input logic eo);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        tick;
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick;
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_held"}, 32'(diff), 32'(held_diff));
        end
        tick;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick;
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        held_diff = ed;
    endtask

    initial begin
        logic [3:0] a_hist [0:23];
        n_total = 0; n_pass = 0; held_diff = '0;
        rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd2; bin = 1'b0;
        tick;
        tick;
        start = 1'b0; rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_res", {29'd0, diff, bout, ovf} >> 0, 32'd0);
        end

        run_op("s9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        run_op("s3m9", 4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1);
        run_op("s5m5b", 4'd5, 4'd5, 1'b1, 4'd15, 1'b1, 1'b0);

        // Second start during SHIFT must be ignored
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        a = 4'd1; b = 4'd1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int e = 3; e <= 10; e++) begin
            tick;
            if (e == 4) begin
                check("ign_done", 32'(done), 32'd1);
                check("ign_diff", 32'(diff), 32'd5);
                check("ign_bout", 32'(bout), 32'd0);
                check("ign_ovf", 32'(ovf), 32'd0);
            end else begin
                check("ign_nodone", 32'(done), 32'd0);
            end
        end
        held_diff = 4'd5;

        // Reset mid-operation aborts and clears the held result
        a = 4'd12; b = 4'd4; bin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        held_diff = 4'd0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("abort_nodone", 32'(done), 32'd0);
        end
        run_op("s0m0", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Back-to-back: accepts at edges 0,6,12,18; results after edges 4,10,16,22
        b = 4'd1; bin = 1'b0;
        for (int e = 0; e < 24; e++) begin
            start = (e < 20);
            a = 4'((e * 5 + 3) % 16);
            a_hist[e] = a;
            tick;
            if (e % 6 == 4) begin
                check("b2b_done", 32'(done), 32'd1);
                check("b2b_diff", 32'(diff), 32'(4'(a_hist[e-4] - 4'd1)));
                check("b2b_bout", 32'(bout), 32'd0);
            end else begin
                check("b2b_nodone", 32'(done), 32'd0);
            end
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor with borrow-in: computes diff = a − b − bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the parallel ripple adder in the arithmetic library. Its start/busy/done handshake lets a controller trade area for latency. Results are registered and held until the next operation completes.

## Interface

- WIDTH, default 4, operand/result width in bits (≥ 2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result valid and newly updated
- diff  output  WIDTH  result a − b − bin mod 2^WIDTH; held between operations
- bout  output  1  borrow-out (1 when a < b + bin unsigned)
- ovf  output  1  signed overflow of the two's-complement subtraction

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: on start=1 capture a, b into shift registers, load borrow FF with bin, clear the bit counter, go to SHIFT. If start=0, stay in IDLE.
- SHIFT: each cycle apply the full subtractor to the current LSBs ai, bi and borrow br.
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
- In the same SHIFT cycle:
  - Shift the a and b registers right by one.
  - Shift d into the MSB of the internal partial-result register.
  - Keep the original a[MSB] and b[MSB] in a side register for ovf.
  - Increment the counter.
- After the WIDTH-th shift, go to DONE.
- DONE: in the edge entering DONE, load diff from the partial register and bout from the final borrow. Load ovf = (aMSB ≠ bMSB) & (diff[MSB] ≠ aMSB). bin does not affect the ovf formula. done=1 for this one cycle. Return to IDLE unconditionally.
- diff, bout and ovf change only on the edge entering DONE. During SHIFT they hold the previous result.
- start is ignored in SHIFT and DONE. There is no queuing, and no error is flagged.
- a, b and bin may change freely after the accepting edge without affecting the operation.
- Counter width is clog2(WIDTH+1).

## Timing

- Reset (rst=1 at an edge) forces:
  - state to IDLE
  - busy, done, diff, bout and ovf to 0
  - the internal shift registers, borrow FF and counter to 0
- Reset wins over any simultaneous start.
- Reset mid-operation aborts the operation. There is no result and no done, and the block is in IDLE on the next cycle.
- Latency: start sampled at edge T0 gives busy=1 from T0. done=1 and the new result are visible in the cycle after edge T0+WIDTH, i.e. WIDTH+1 edges after acceptance.
- busy falls together with done at the edge leaving DONE.
- Throughput: with start held high, a new operation is accepted at the first IDLE edge. That is one result per WIDTH+2 cycles.
- done is never high for two consecutive cycles.

## Test plan

- Reset, then idle 3 cycles → busy=done=diff=bout=ovf=0 throughout.
- WIDTH=4, a=9, b=3, bin=0, start pulsed at T0 → done only in the cycle after T0+4, with diff=6, bout=0, ovf=1. Before that, diff stays 0.
- a=3, b=9, bin=0 → diff=10 (4'b1010), bout=1, ovf=1. Then a=5, b=5, bin=1 → diff=15, bout=1, ovf=0.
- Accept a=7, b=2, then pulse start again at T0+2 with a=1, b=1 → second start ignored. Result is diff=5, bout=0, ovf=0, with a single done pulse.
- Start a=12, b=4, assert rst at T0+2 → busy=0 from the next cycle, diff/bout/ovf=0, no done. A subsequent start with a=0, b=0, bin=0 gives diff=0, bout=0 after 5 edges.
- Hold start=1 for 20 cycles, b=1, bin=0, a changing each cycle → done pulses every 6 cycles. Each diff equals the a sampled at its accepting edge minus 1, mod 16.
